// File: rtl/vx_issue_scoreboard_if.sv
// Issue-scoreboard bus: instruction-buffer head, dispatch handshake and
// writeback release channel.
//   master : instruction buffer / dispatch / writeback side (drives head,
//            issue_ready and writeback packets)
//   slave  : the scoreboard (drives ibuf_ready and issue_valid)
interface vx_issue_scoreboard_if #(
  parameter int NW_BITS = 2,
  parameter int NR_BITS = 6
);
  logic               ibuf_valid;
  logic               ibuf_ready;
  logic [NW_BITS-1:0] ibuf_wid;
  logic               ibuf_wb;
  logic [NR_BITS-1:0] ibuf_rd;
  logic [NR_BITS-1:0] ibuf_rs1;
  logic [NR_BITS-1:0] ibuf_rs2;
  logic [NR_BITS-1:0] ibuf_rs3;
  logic               issue_valid;
  logic               issue_ready;
  logic               wb_valid;
  logic [NW_BITS-1:0] wb_wid;
  logic [NR_BITS-1:0] wb_rd;
  logic               wb_eop;

  modport master (
    output ibuf_valid, ibuf_wid, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3,
    output issue_ready, wb_valid, wb_wid, wb_rd, wb_eop,
    input  ibuf_ready, issue_valid
  );

  modport slave (
    input  ibuf_valid, ibuf_wid, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3,
    input  issue_ready, wb_valid, wb_wid, wb_rd, wb_eop,
    output ibuf_ready, issue_valid
  );
endinterface

// File: rtl/vx_issue_scoreboard.sv
// Per-warp pending-write scoreboard between the instruction buffer and
// dispatch. Stalls the head instruction on RAW/WAW hazards, reserves rd on
// issue, releases it on the final writeback packet.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   sb (slave)   : head instruction, dispatch handshake, writeback release
//   perf_stalls  : saturating count of hazard-stall cycles
//   deadlock     : sticky, hazard stall lasted STALL_TIMEOUT consecutive cycles
//   err_release  : sticky, release of a register that was not pending
module vx_issue_scoreboard #(
  parameter int NUM_WARPS     = 4,
  parameter int NW_BITS       = 2,
  parameter int NUM_REGS      = 64,
  parameter int NR_BITS       = 6,
  parameter int STALL_TIMEOUT = 10000,
  parameter int PERF_BITS     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_issue_scoreboard_if.slave sb,
  output logic [PERF_BITS-1:0] perf_stalls,
  output logic                 deadlock,
  output logic                 err_release
);
  localparam int TW = $clog2(STALL_TIMEOUT + 1);

  logic [NUM_REGS-1:0] pending [NUM_WARPS];
  logic [NUM_REGS-1:0] rel_mask;
  logic [NUM_REGS-1:0] res_mask;
  logic [NUM_REGS-1:0] head_eff;
  logic                rel;
  logic                hazard;
  logic                fire;
  logic                reserve;
  logic                res_same;
  logic                stall;
  logic [TW-1:0]       stall_left;

  assign rel = sb.wb_valid & sb.wb_eop;

  always_comb begin
    rel_mask = '0;
    if (rel) rel_mask[sb.wb_rd] = 1'b1;
  end

  // Head row with this cycle's release already applied (zero-bubble bypass).
  // Bit 0 is the hard-wired zero register and never blocks.
  always_comb begin
    head_eff = pending[sb.ibuf_wid];
    if (sb.wb_wid == sb.ibuf_wid) head_eff = head_eff & ~rel_mask;
    head_eff[0] = 1'b0;
  end

  assign hazard = head_eff[sb.ibuf_rs1] | head_eff[sb.ibuf_rs2] | head_eff[sb.ibuf_rs3]
                | (sb.ibuf_wb & head_eff[sb.ibuf_rd]);

  assign sb.issue_valid = sb.ibuf_valid & ~hazard;
  assign sb.ibuf_ready  = sb.issue_ready & ~hazard;
  assign fire           = sb.issue_valid & sb.issue_ready;
  assign stall          = sb.ibuf_valid & hazard;
  assign reserve        = fire & sb.ibuf_wb & (sb.ibuf_rd != '0);
  assign res_same       = reserve & (sb.ibuf_wid == sb.wb_wid) & (sb.ibuf_rd == sb.wb_rd);

  always_comb begin
    res_mask = '0;
    if (reserve) res_mask[sb.ibuf_rd] = 1'b1;
  end

  // Release is applied before reserve so a same-cycle reserve of the same
  // register leaves the bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) pending[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pending[w] <= (pending[w] & ~((sb.wb_wid == NW_BITS'(w)) ? rel_mask : '0))
                    | ((sb.ibuf_wid == NW_BITS'(w)) ? res_mask : '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_release <= 1'b0;
    end else if (rel && !pending[sb.wb_wid][sb.wb_rd] && !res_same) begin
      err_release <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stalls <= '0;
    end else if (stall && perf_stalls != '1) begin
      perf_stalls <= perf_stalls + PERF_BITS'(1);
    end
  end

  // Watchdog: stall_left counts remaining consecutive stall cycles; it is
  // reloaded on any non-stall cycle and deadlock fires on the edge it hits 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_left <= TW'(STALL_TIMEOUT);
      deadlock   <= 1'b0;
    end else begin
      if (!stall) begin
        stall_left <= TW'(STALL_TIMEOUT);
      end else if (stall_left != '0) begin
        stall_left <= stall_left - TW'(1);
      end
      if (stall && stall_left == TW'(1)) deadlock <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vx_issue_scoreboard.sv
module tb_vx_issue_scoreboard;
  localparam int NUM_WARPS = 4;
  localparam int NW_BITS   = 2;
  localparam int NUM_REGS  = 64;
  localparam int NR_BITS   = 6;
  localparam int TIMEOUT   = 8;
  localparam int PBITS     = 6;
  localparam int PMAX      = (1 << PBITS) - 1;

  logic             clk;
  logic             reset;
  logic [PBITS-1:0] perf_stalls;
  logic             deadlock;
  logic             err_release;

  vx_issue_scoreboard_if #(.NW_BITS(NW_BITS), .NR_BITS(NR_BITS)) bus ();

  vx_issue_scoreboard #(
    .NUM_WARPS(NUM_WARPS), .NW_BITS(NW_BITS), .NUM_REGS(NUM_REGS), .NR_BITS(NR_BITS),
    .STALL_TIMEOUT(TIMEOUT), .PERF_BITS(PBITS)
  ) dut (
    .clk(clk), .reset(reset), .sb(bus),
    .perf_stalls(perf_stalls), .deadlock(deadlock), .err_release(err_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: a plain boolean table plus scalar counters.
  bit m_pend [NUM_WARPS][NUM_REGS];
  int m_perf;
  int m_consec;
  bit m_dl;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m_pend[w, r]) m_pend[w][r] = 1'b0;
    m_perf = 0; m_consec = 0; m_dl = 0; m_err = 0;
  endtask

  function automatic bit blocked(input int w, input int r);
    bit released;
    released = bus.wb_valid && bus.wb_eop && (int'(bus.wb_wid) == w) && (int'(bus.wb_rd) == r);
    return (r != 0) && m_pend[w][r] && !released;
  endfunction

  function automatic bit m_hazard();
    int w;
    w = int'(bus.ibuf_wid);
    return blocked(w, int'(bus.ibuf_rs1)) || blocked(w, int'(bus.ibuf_rs2)) ||
           blocked(w, int'(bus.ibuf_rs3)) || (bus.ibuf_wb && blocked(w, int'(bus.ibuf_rd)));
  endfunction

  task automatic set_head(input bit v, input int wid, input bit wb, input int rd,
                          input int rs1, input int rs2, input int rs3);
    bus.ibuf_valid = v;
    bus.ibuf_wid   = NW_BITS'(wid);
    bus.ibuf_wb    = wb;
    bus.ibuf_rd    = NR_BITS'(rd);
    bus.ibuf_rs1   = NR_BITS'(rs1);
    bus.ibuf_rs2   = NR_BITS'(rs2);
    bus.ibuf_rs3   = NR_BITS'(rs3);
  endtask

  task automatic set_wb(input bit v, input int wid, input int rd, input bit eop);
    bus.wb_valid = v;
    bus.wb_wid   = NW_BITS'(wid);
    bus.wb_rd    = NR_BITS'(rd);
    bus.wb_eop   = eop;
  endtask

  // Entered about 1 time unit after a rising edge with inputs applied;
  // checks at +3, steps the model across the edge, returns at edge+1.
  task automatic cycle();
    bit hz, fire, stall, rel, res;
    #2;
    hz = m_hazard();
    chk("issue_valid", 32'(bus.issue_valid), 32'(bus.ibuf_valid && !hz));
    chk("ibuf_ready",  32'(bus.ibuf_ready),  32'(bus.issue_ready && !hz));
    chk("perf_stalls", 32'(perf_stalls), 32'(m_perf));
    chk("deadlock",    32'(deadlock), 32'(m_dl));
    chk("err_release", 32'(err_release), 32'(m_err));
    fire  = bus.ibuf_valid && !hz && bus.issue_ready;
    stall = bus.ibuf_valid && hz;
    rel   = bus.wb_valid && bus.wb_eop;
    res   = fire && bus.ibuf_wb && (bus.ibuf_rd != 0);
    @(posedge clk);
    if (rel) begin
      if (!m_pend[bus.wb_wid][bus.wb_rd] &&
          !(res && bus.ibuf_wid == bus.wb_wid && bus.ibuf_rd == bus.wb_rd)) m_err = 1;
      m_pend[bus.wb_wid][bus.wb_rd] = 1'b0;
    end
    if (res) m_pend[bus.ibuf_wid][bus.ibuf_rd] = 1'b1;
    if (stall) begin
      if (m_perf < PMAX) m_perf++;
      m_consec++;
      if (m_consec >= TIMEOUT) m_dl = 1;
    end else begin
      m_consec = 0;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus.issue_ready = 1'b1;
    set_head(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0);
    model_clear();
    #12;
    chk("rst_perf", 32'(perf_stalls), 32'd0);
    chk("rst_deadlock", 32'(deadlock), 32'd0);
    chk("rst_err", 32'(err_release), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // reserve then RAW stall, released by bypass
    set_head(1, 0, 1, 5, 0, 0, 0); #1; chk("raw_reserve_fire", 32'(bus.issue_valid), 32'd1); cycle();
    set_head(1, 0, 0, 0, 5, 0, 0); #1; chk("raw_stall_iv", 32'(bus.issue_valid), 32'd0);
    chk("raw_stall_rdy", 32'(bus.ibuf_ready), 32'd0); cycle();
    chk("raw_perf", 32'(perf_stalls), 32'd1);
    set_wb(1, 0, 5, 1); #1; chk("raw_bypass", 32'(bus.issue_valid), 32'd1); cycle();
    set_wb(0, 0, 0, 0);

    // multi-packet writeback
    set_head(1, 1, 1, 7, 0, 0, 0); cycle();
    set_head(1, 1, 0, 0, 0, 7, 0);
    set_wb(1, 1, 7, 0); #1; chk("mp_eop0_a", 32'(bus.issue_valid), 32'd0); cycle();
    #1; chk("mp_eop0_b", 32'(bus.issue_valid), 32'd0); cycle();
    set_wb(1, 1, 7, 1); #1; chk("mp_eop1", 32'(bus.issue_valid), 32'd1); cycle();
    set_wb(0, 0, 0, 0);

    // cross-warp isolation and WAW
    set_head(1, 2, 1, 3, 0, 0, 0); cycle();
    set_head(1, 3, 0, 0, 3, 0, 0); #1; chk("xwarp_free", 32'(bus.issue_valid), 32'd1); cycle();
    set_head(1, 2, 1, 3, 0, 0, 0); #1; chk("waw_stall", 32'(bus.issue_valid), 32'd0); cycle();
    set_head(0, 0, 0, 0, 0, 0, 0); set_wb(1, 2, 3, 1); cycle();
    set_wb(0, 0, 0, 0);

    // same-cycle release and reserve of w0 r9
    set_head(1, 0, 1, 9, 0, 0, 0); cycle();
    set_head(1, 0, 1, 9, 9, 0, 0); set_wb(1, 0, 9, 1); #1;
    chk("rr_fire", 32'(bus.issue_valid), 32'd1); cycle();
    set_wb(0, 0, 0, 0);
    set_head(1, 0, 0, 0, 9, 0, 0); #1; chk("rr_still_set", 32'(bus.issue_valid), 32'd0); cycle();
    chk("rr_no_err", 32'(err_release), 32'd0);

    // zero register, unreserved release
    set_head(1, 1, 1, 0, 0, 0, 0); cycle();
    set_head(1, 1, 1, 0, 0, 0, 0); #1; chk("r0_never_pending", 32'(bus.issue_valid), 32'd1); cycle();
    set_head(0, 0, 0, 0, 0, 0, 0); set_wb(1, 0, 12, 1); cycle();
    set_wb(0, 0, 0, 0);
    chk("err_set", 32'(err_release), 32'd1);
    cycle();
    chk("err_sticky", 32'(err_release), 32'd1);

    // watchdog on w0 r9 (still pending)
    set_head(1, 0, 0, 0, 9, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle();
    chk("wd_before", 32'(deadlock), 32'd0);
    cycle();
    chk("wd_hit", 32'(deadlock), 32'd1);
    set_wb(1, 0, 9, 1); cycle();
    set_wb(0, 0, 0, 0);
    chk("wd_sticky", 32'(deadlock), 32'd1);

    // async reset in the middle of a stall
    set_head(1, 0, 1, 20, 0, 0, 0); cycle();
    set_head(1, 0, 0, 0, 20, 0, 0); cycle(); cycle();
    #3; reset = 1'b0; #1;
    chk("arst_perf", 32'(perf_stalls), 32'd0);
    chk("arst_deadlock", 32'(deadlock), 32'd0);
    chk("arst_err", 32'(err_release), 32'd0);
    chk("arst_table", 32'(bus.issue_valid), 32'd1);
    model_clear();
    @(posedge clk); #2; reset = 1'b1;

    // randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      set_head($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7));
      set_wb($urandom_range(0, 9) < 4, $urandom_range(0, 3), $urandom_range(0, 7),
             $urandom_range(0, 2) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
